alu_cmd_driver: RTL and testbench

//  Initiator for the 5-bit ALU: accepts one command (op, A, B) over a valid/ready

---
 rtl/alu_cmd_driver.sv | 116 +++++++++++
 tb/tb_alu_cmd_driver.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_driver.sv
// alu_cmd_driver: valid/ready command front end that drives the ALU from registers
// and returns the settled Result/CarryOut over a valid/ready response port.
module alu_cmd_driver #(
    parameter int DATA_W        = 5,
    parameter int OP_W          = 3,
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_ctrl,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_carry,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_carry,
    output logic              rsp_err,
    output logic [CNT_W-1:0]  op_count
);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SW-1:0] SETTLE_INIT = SW'(SETTLE_CYCLES);

    typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [OP_W-1:0]   alu_ctrl_q, alu_ctrl_d;
    logic [SW-1:0]     settle_q, settle_d;
    logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
    logic              rsp_carry_q, rsp_carry_d, rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0]  op_count_q, op_count_d;

    always_comb begin
        state_d      = state_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_ctrl_d   = alu_ctrl_q;
        settle_d     = settle_q;
        rsp_result_d = rsp_result_q;
        rsp_carry_d  = rsp_carry_q;
        rsp_err_d    = rsp_err_q;
        op_count_d   = op_count_q;
        case (state_q)
            IDLE: if (cmd_valid) begin
                if (!cmd_op[OP_W-1]) begin
                    alu_a_d    = cmd_a;
                    alu_b_d    = cmd_b;
                    alu_ctrl_d = cmd_op;
                    settle_d   = SETTLE_INIT;
                    state_d    = DRIVE;
                end else begin
                    rsp_err_d    = 1'b1;
                    rsp_result_d = '0;
                    rsp_carry_d  = 1'b0;
                    state_d      = RESP;
                end
            end
            DRIVE: begin
                settle_d = settle_q - SW'(1);
                if (settle_q == SW'(1)) begin
                    rsp_result_d = alu_result;
                    rsp_carry_d  = alu_carry;
                    rsp_err_d    = 1'b0;
                    state_d      = RESP;
                end
            end
            RESP: if (rsp_ready) begin
                state_d    = IDLE;
                op_count_d = rsp_err_q ? op_count_q : op_count_q + CNT_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_ctrl_q   <= '0;
            settle_q     <= '0;
            rsp_result_q <= '0;
            rsp_carry_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            op_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_ctrl_q   <= alu_ctrl_d;
            settle_q     <= settle_d;
            rsp_result_q <= rsp_result_d;
            rsp_carry_q  <= rsp_carry_d;
            rsp_err_q    <= rsp_err_d;
            op_count_q   <= op_count_d;
        end
    end

    assign cmd_ready  = (state_q == IDLE);
    assign rsp_valid  = (state_q == RESP);
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_ctrl   = alu_ctrl_q;
    assign rsp_result = rsp_result_q;
    assign rsp_carry  = rsp_carry_q;
    assign rsp_err    = rsp_err_q;
    assign op_count   = op_count_q;
endmodule

// File: tb/tb_alu_cmd_driver.sv
// tb_alu_cmd_driver: two driver instances (settle 1 / count 8 bits, settle 3 / count 2 bits)
// each wired to a behavioural 5-bit ALU, checked against a transaction-level model.
module tb_alu_cmd_driver;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid[2], cmd_ready[2], rsp_valid[2], rsp_ready[2];
    logic [2:0] cmd_op[2], alu_ctrl[2];
    logic [4:0] cmd_a[2], cmd_b[2], alu_a[2], alu_b[2], alu_result[2], rsp_result[2];
    logic       alu_carry[2], rsp_carry[2], rsp_err[2];
    logic [7:0] oc0;
    logic [1:0] oc1;

    int n_cmp = 0, n_err = 0;
    logic [4:0] m_a[2], m_b[2];
    logic [2:0] m_ctrl[2];
    int         m_cnt[2];

    always #5 clk = ~clk;

    // ALU: 000 add, 001 mask (A & ~B), 010 shift-left by B[2:0], 011 and
    function automatic logic [5:0] alu_f(input logic [2:0] op, input logic [4:0] a, input logic [4:0] b);
        int r;
        case (op)
            3'd0: r = int'(a) + int'(b);
            3'd1: r = int'(a & ~b);
            3'd2: r = (int'(a) << b[2:0]) % 64;
            3'd3: r = int'(a & b);
            default: r = 0;
        endcase
        return 6'(r);
    endfunction

    assign {alu_carry[0], alu_result[0]} = alu_f(alu_ctrl[0], alu_a[0], alu_b[0]);
    assign {alu_carry[1], alu_result[1]} = alu_f(alu_ctrl[1], alu_a[1], alu_b[1]);

    alu_cmd_driver #(.SETTLE_CYCLES(1), .CNT_W(8)) u_s1 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
        .cmd_op(cmd_op[0]), .cmd_a(cmd_a[0]), .cmd_b(cmd_b[0]), .alu_a(alu_a[0]),
        .alu_b(alu_b[0]), .alu_ctrl(alu_ctrl[0]), .alu_result(alu_result[0]),
        .alu_carry(alu_carry[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_result(rsp_result[0]), .rsp_carry(rsp_carry[0]), .rsp_err(rsp_err[0]),
        .op_count(oc0)
    );

    alu_cmd_driver #(.SETTLE_CYCLES(3), .CNT_W(2)) u_s3 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
        .cmd_op(cmd_op[1]), .cmd_a(cmd_a[1]), .cmd_b(cmd_b[1]), .alu_a(alu_a[1]),
        .alu_b(alu_b[1]), .alu_ctrl(alu_ctrl[1]), .alu_result(alu_result[1]),
        .alu_carry(alu_carry[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_result(rsp_result[1]), .rsp_carry(rsp_carry[1]), .rsp_err(rsp_err[1]),
        .op_count(oc1)
    );

    function automatic int get_cnt(input int i);
        return (i == 0) ? int'(oc0) : int'(oc1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_alu(input int i, input string tag);
        chk({tag, "_alu_a"}, 32'(alu_a[i]), 32'(m_a[i]));
        chk({tag, "_alu_b"}, 32'(alu_b[i]), 32'(m_b[i]));
        chk({tag, "_alu_ctrl"}, 32'(alu_ctrl[i]), 32'(m_ctrl[i]));
    endtask

    task automatic do_op(input int i, input logic [2:0] op, input logic [4:0] a, input logic [4:0] b, input int hold);
        int         s = (i == 0) ? 1 : 3;
        int         lat = 0;
        logic       legal = !op[2];
        logic [5:0] exp = legal ? alu_f(op, a, b) : 6'd0;
        chk("cmd_ready_idle", 32'(cmd_ready[i]), 32'd1);
        cmd_valid[i] = 1'b1; cmd_op[i] = op; cmd_a[i] = a; cmd_b[i] = b; rsp_ready[i] = 1'b0;
        @(posedge clk); #1;
        cmd_valid[i] = 1'b0;
        if (legal) begin
            m_a[i] = a; m_b[i] = b; m_ctrl[i] = op;
        end
        chk_alu(i, "accept");
        while (!rsp_valid[i] && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 32'(lat), legal ? 32'(s) : 32'd0);
        chk("rsp_result", 32'(rsp_result[i]), 32'(exp[4:0]));
        chk("rsp_carry", 32'(rsp_carry[i]), 32'(exp[5]));
        chk("rsp_err", 32'(rsp_err[i]), legal ? 32'd0 : 32'd1);
        for (int k = 0; k < hold; k++) begin
            cmd_valid[i] = 1'b1; cmd_op[i] = 3'($urandom_range(0, 3));
            cmd_a[i] = 5'($urandom); cmd_b[i] = 5'($urandom);
            @(posedge clk); #1;
            chk("hold_valid", 32'(rsp_valid[i]), 32'd1);
            chk("hold_result", 32'({rsp_err[i], rsp_carry[i], rsp_result[i]}), 32'({~legal, exp}));
            chk("hold_cmd_ready", 32'(cmd_ready[i]), 32'd0);
            chk_alu(i, "hold");
        end
        cmd_valid[i] = 1'b0; rsp_ready[i] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[i] = 1'b0;
        if (legal) m_cnt[i] = (m_cnt[i] + 1) % ((i == 0) ? 256 : 4);
        chk("post_rsp_valid", 32'(rsp_valid[i]), 32'd0);
        chk("post_cmd_ready", 32'(cmd_ready[i]), 32'd1);
        chk("op_count", 32'(get_cnt(i)), 32'(m_cnt[i]));
    endtask

    task automatic chk_reset(input int i);
        chk_alu(i, "rst");
        chk("rst_rsp_valid", 32'(rsp_valid[i]), 32'd0);
        chk("rst_rsp", 32'({rsp_err[i], rsp_carry[i], rsp_result[i]}), 32'd0);
        chk("rst_op_count", 32'(get_cnt(i)), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready[i]), 32'd1);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_a[i] = '0; m_b[i] = '0; m_ctrl[i] = '0; m_cnt[i] = 0;
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            cmd_valid[i] = 1'b0; rsp_ready[i] = 1'b0;
            cmd_op[i] = '0; cmd_a[i] = '0; cmd_b[i] = '0;
        end
        model_reset();
        #12;
        chk_reset(0);
        chk_reset(1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_op(0, 3'b000, 5'd20, 5'd15, 0);
        do_op(0, 3'b011, 5'd22, 5'd13, 5);
        do_op(0, 3'b101, 5'd7, 5'd9, 2);
        do_op(1, 3'b000, 5'd1, 5'd1, 0);
        cmd_valid[1] = 1'b1; cmd_op[1] = 3'b000; cmd_a[1] = 5'd9; cmd_b[1] = 5'd4;
        @(posedge clk); #1;
        cmd_valid[1] = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk_reset(0);
        chk_reset(1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            chk("no_rsp_after_rst", 32'(rsp_valid[1]), 32'd0);
        end
        for (int k = 0; k < 5; k++) do_op(1, 3'($urandom_range(0, 3)), 5'($urandom), 5'($urandom), 0);
        for (int k = 0; k < 60; k++)
            do_op(k % 2, 3'($urandom_range(0, 7)), 5'($urandom), 5'($urandom), int'($urandom_range(0, 3)));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
